mvau_weight_streamer: RTL and testbench

//  Multi-PE weight store plus address sequencer for the MVAU datapath. Holds PE banks of

---
 rtl/mvau_weight_streamer.sv | 200 ++++++++++++++++++++
 tb/tb_mvau_weight_streamer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mvau_weight_streamer.sv
// Multi-bank MVAU weight store with runtime load port and a
// multi-pass address sequencer streaming one word per bank per beat.
module mvau_weight_streamer #(
  parameter int PE           = 2,
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 2,
  parameter int PE_BW        = 1
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      start,
  input  logic [15:0]               num_reps,
  input  logic                      clear,
  output logic                      busy,
  output logic                      done,
  input  logic                      wr_en,
  input  logic [PE_BW-1:0]          wr_pe,
  input  logic [WMEM_ADDR_BW-1:0]   wr_addr,
  input  logic [SIMD*TW-1:0]        wr_data,
  output logic                      wr_err,
  output logic                      out_v,
  input  logic                      out_rdy,
  output logic [PE*SIMD*TW-1:0]     out_data,
  output logic                      out_last
);

  localparam int DW   = SIMD * TW;
  localparam int OW   = PE * DW;
  localparam int AI_W = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1;
  localparam int PI_W = (PE > 1) ? $clog2(PE) : 1;

  localparam logic [PE_BW:0]        PE_LIM  = PE[PE_BW:0];
  localparam logic [WMEM_ADDR_BW:0] A_LIM   = WMEM_DEPTH[WMEM_ADDR_BW:0];
  localparam logic [AI_W-1:0]       A_LAST  = AI_W'(WMEM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_n;

  logic [DW-1:0]   mem [PE][WMEM_DEPTH];
  logic [OW-1:0]   rd_word;
  logic [OW-1:0]   rd_q;
  logic            rd_vld;
  logic            rd_last;

  logic [AI_W-1:0] addr;
  logic [15:0]     pass;
  logic [15:0]     reps;

  logic [OW-1:0]   buf_d [2];
  logic [1:0]      buf_l;
  logic            wp;
  logic            rp;
  logic [1:0]      count;

  logic            go;
  logic            go_zero;
  logic            issue;
  logic            full;
  logic            push;
  logic            pop;
  logic            drain_done;
  logic            wr_ok;
  logic            at_end;

  assign go      = (state == IDLE) && start && (num_reps != 16'd0);
  assign go_zero = (state == IDLE) && start && (num_reps == 16'd0);
  assign push    = rd_vld;
  assign pop     = out_v && out_rdy;
  assign full    = (count == 2'd2) || ((count == 2'd1) && rd_vld);
  assign at_end  = (addr == A_LAST) && (pass == reps - 16'd1);

  assign wr_ok = wr_en && (state == IDLE)
              && ({1'b0, wr_pe} < PE_LIM)
              && ({1'b0, wr_addr} < A_LIM);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (go) state_n = RUN;
      RUN:     if (issue && at_end) state_n = DRAIN;
      DRAIN:   if ((count == 2'd0) && !rd_vld) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (clear) state_n = IDLE;
  end

  // A pop this cycle frees a slot, so issuing against it keeps the stream bubble-free
  always_comb begin
    busy       = 1'b0;
    issue      = 1'b0;
    drain_done = 1'b0;
    unique case (state)
      IDLE:    ;
      RUN: begin
        busy  = 1'b1;
        issue = !full || pop;
      end
      DRAIN: begin
        busy       = 1'b1;
        drain_done = (count == 2'd0) && !rd_vld;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (wr_ok) mem[wr_pe[PI_W-1:0]][wr_addr[AI_W-1:0]] <= wr_data;
  end

  always_comb begin
    rd_word = '0;
    for (int p = 0; p < PE; p++) rd_word[p*DW +: DW] = mem[p][addr];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr <= '0;
      pass <= '0;
      reps <= '0;
    end else if (clear) begin
      addr <= '0;
      pass <= '0;
    end else if (go) begin
      addr <= '0;
      pass <= '0;
      reps <= num_reps;
    end else if (issue) begin
      if (addr == A_LAST) begin
        addr <= '0;
        pass <= pass + 16'd1;
      end else begin
        addr <= addr + AI_W'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
      rd_q    <= '0;
    end else begin
      rd_vld  <= issue && !clear;
      rd_last <= issue && (addr == A_LAST);
      if (issue) rd_q <= rd_word;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      buf_d[0] <= '0;
      buf_d[1] <= '0;
      buf_l    <= '0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      count    <= '0;
    end else if (clear) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= '0;
    end else begin
      if (push) begin
        buf_d[wp] <= rd_q;
        buf_l[wp] <= rd_last;
        wp        <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  logic zero_done;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      zero_done <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      zero_done <= go_zero && !clear;
      wr_err    <= wr_en && !wr_ok;
    end
  end

  assign done     = (drain_done && !clear) || zero_done;
  assign out_v    = (count != 2'd0);
  assign out_data = out_v ? buf_d[rp] : '0;
  assign out_last = out_v && buf_l[rp];

endmodule

// File: tb/tb_mvau_weight_streamer.sv
// Directed bench for mvau_weight_streamer: scoreboarded beats,
// stall hold checks, write rejection, clear and async reset.
module tb_mvau_weight_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_reps;
  logic        clear;
  logic        busy;
  logic        done;
  logic        wr_en;
  logic [1:0]  wr_pe;
  logic [2:0]  wr_addr;
  logic [1:0]  wr_data;
  logic        wr_err;
  logic        out_v;
  logic        out_rdy;
  logic [3:0]  out_data;
  logic        out_last;

  always #5 clk = ~clk;

  mvau_weight_streamer #(
    .PE(2), .SIMD(2), .TW(1), .WMEM_DEPTH(4),
    .WMEM_ADDR_BW(3), .PE_BW(2)
  ) dut (
    .aclk(clk), .aresetn(rst_n), .start(start),
    .num_reps(num_reps), .clear(clear), .busy(busy),
    .done(done), .wr_en(wr_en), .wr_pe(wr_pe),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .out_v(out_v), .out_rdy(out_rdy), .out_data(out_data),
    .out_last(out_last)
  );

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  int d0;
  logic [1:0] mdl [2][4];
  logic [4:0] q[$];
  logic       hold_en = 1'b0;
  logic       stall_prev = 1'b0;
  logic [4:0] stall_word = '0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] p, input logic [2:0] a,
                    input logic [1:0] d);
    wr_en = 1'b1; wr_pe = p; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic push_stream(input int reps);
    for (int r = 0; r < reps; r++)
      for (int a = 0; a < 4; a++)
        q.push_back({(a == 3), mdl[1][a], mdl[0][a]});
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 80 && q.size() != 0; i++) @(posedge clk);
    check(tag, q.size(), 0);
  endtask

  always @(negedge clk) begin
    logic [4:0] e;
    if (hold_en && stall_prev) begin
      check("hold_v", out_v, 1'b1);
      check("hold_d", {out_last, out_data}, stall_word);
    end
    if (out_v && out_rdy) begin
      if (q.size() == 0) check("extra_beat", out_v, 1'b0);
      else begin
        e = q.pop_front();
        check("beat", {out_last, out_data}, e);
      end
    end
    stall_prev = hold_en && out_v && !out_rdy;
    stall_word = {out_last, out_data};
    if (done) done_cnt++;
  end

  initial begin
    rst_n = 1'b0; start = 0; num_reps = 0; clear = 0;
    wr_en = 0; wr_pe = 0; wr_addr = 0; wr_data = 0; out_rdy = 0;
    #2;
    check("rst_v", out_v, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", out_data, 0);
    check("rst_werr", wr_err, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    hold_en = 1'b1;

    // load
    for (int a = 0; a < 4; a++) begin
      mdl[0][a] = 2'(a);
      mdl[1][a] = 2'(3 - a);
      wr(2'd0, 3'(a), mdl[0][a]);
      check("load_werr0", wr_err, 0);
      wr(2'd1, 3'(a), mdl[1][a]);
    end

    // test 1: full-rate stream, 2 passes
    d0 = done_cnt;
    push_stream(2);
    num_reps = 16'd2; start = 1'b1; out_rdy = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("t1_busy", busy, 1);
    check("t1_lat0", out_v, 0);
    @(negedge clk);
    check("t1_lat1", out_v, 0);
    @(negedge clk);
    check("t1_lat2", out_v, 1);
    wait_drain("t1_drain");
    @(negedge clk);
    check("t1_done", done, 1);
    check("t1_v_off", out_v, 0);
    @(negedge clk);
    check("t1_done_off", done, 0);
    check("t1_idle", busy, 0);
    check("t1_done_cnt", done_cnt, d0 + 1);

    // test 2: back-pressure pattern 1,0,0,1
    tick();
    d0 = done_cnt;
    push_stream(2);
    num_reps = 16'd2; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 120 && q.size() != 0; i++) begin
      out_rdy = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    check("t2_drain", q.size(), 0);
    out_rdy = 1'b1;
    repeat (3) tick();
    check("t2_done_cnt", done_cnt, d0 + 1);
    check("t2_idle", busy, 0);

    // test 3: rejected writes
    push_stream(1);
    num_reps = 16'd1; start = 1'b1;
    tick(); start = 1'b0;
    wr(2'd0, 3'd0, 2'd3);
    check("t3_werr_run", wr_err, 1);
    tick();
    check("t3_werr_clr", wr_err, 0);
    wait_drain("t3_drain");
    repeat (3) tick();
    wr(2'd2, 3'd0, 2'd1);
    check("t3_werr_pe", wr_err, 1);
    wr(2'd0, 3'd4, 2'd1);
    check("t3_werr_addr", wr_err, 1);
    tick();
    check("t3_werr_off", wr_err, 0);

    // test 4: zero reps
    d0 = done_cnt;
    num_reps = 16'd0; start = 1'b1;
    tick(); start = 1'b0;
    check("t4_done", done, 1);
    check("t4_busy", busy, 0);
    check("t4_v", out_v, 0);
    tick();
    check("t4_done_off", done, 0);
    check("t4_done_cnt", done_cnt, d0 + 1);

    // test 5: clear after 3rd beat with stall
    d0 = done_cnt;
    push_stream(2);
    num_reps = 16'd2; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 40 && q.size() > 5; i++) tick();
    check("t5_three", q.size(), 5);
    out_rdy = 1'b0;
    hold_en = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t5_v_off", out_v, 0);
    check("t5_busy", busy, 0);
    q.delete();
    repeat (4) tick();
    check("t5_no_done", done_cnt, d0);
    hold_en = 1'b1;
    push_stream(1);
    num_reps = 16'd1; start = 1'b1; out_rdy = 1'b1;
    tick(); start = 1'b0;
    wait_drain("t5_restart");
    repeat (3) tick();

    // test 6: async reset mid-stream
    push_stream(2);
    num_reps = 16'd2; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 40 && q.size() > 6; i++) tick();
    #2;
    hold_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_v", out_v, 0);
    check("t6_busy", busy, 0);
    check("t6_data", out_data, 0);
    check("t6_last", out_last, 0);
    check("t6_done", done, 0);
    q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    hold_en = 1'b1;
    push_stream(2);
    num_reps = 16'd2; start = 1'b1;
    tick(); start = 1'b0;
    wait_drain("t6_restream");
    repeat (3) tick();
    check("t6_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
